// File: rtl/ahb_lite_protocol_checker.sv
// Passive AHB-Lite protocol checker: tracks the address/data pipeline and burst progress,
// reports rule violations as pulses, sticky bits and first-error capture, plus saturating counters.
module ahb_lite_protocol_checker #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int NUM_SLAVES = 3,
   parameter int SLAVE_SPAN = 1024,
   parameter int MAX_WAIT   = 16,
   parameter int CNT_W      = 16
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   input  logic              clr,
   output logic [6:0]        err_pulse,
   output logic [6:0]        err_sticky,
   output logic [2:0]        first_code,
   output logic [ADDR_W-1:0] first_addr,
   output logic [CNT_W-1:0]  xfer_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 2);
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_SLAVES * SLAVE_SPAN);

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t              state;
   logic [4:0]          beats_left;
   logic [2:0]          burst_q;
   logic [ADDR_W-1:0]   last_addr;
   logic [ADDR_W-1:0]   prev_addr;
   logic                prev_write;
   logic [2:0]          prev_size;
   logic [2:0]          prev_burst;
   logic                prev_pend;
   logic                dp_valid;
   logic                dp_write;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [6:0]          viol;
   logic                xdata;

   logic is_idle, is_busy, is_nonseq, is_seq, accept, dp_done, resp_err, fixed_q;
   logic [ADDR_W-1:0] size_bytes, incr_addr, block_mask, seq_next;

   function automatic logic [4:0] burst_len(input logic [2:0] b);
      case (b)
         3'd2, 3'd3: burst_len = 5'd4;
         3'd4, 3'd5: burst_len = 5'd8;
         3'd6, 3'd7: burst_len = 5'd16;
         default:    burst_len = 5'd1;
      endcase
   endfunction

   function automatic logic [2:0] lowest_set(input logic [6:0] v);
      lowest_set = 3'd0;
      for (int i = 6; i >= 0; i--)
         if (v[i]) lowest_set = 3'(i);
   endfunction

   assign is_idle    = (HTRANS == 2'b00);
   assign is_busy    = (HTRANS == 2'b01);
   assign is_nonseq  = (HTRANS == 2'b10);
   assign is_seq     = (HTRANS == 2'b11);
   assign accept     = HREADY && HTRANS[1];
   assign dp_done    = dp_valid && HREADY;
   assign resp_err   = dp_valid && HRESP;
   assign fixed_q    = (burst_q >= 3'd2);

   // Wrapping bursts keep the upper address bits and wrap the low bits inside a len*size block.
   assign size_bytes = ADDR_W'(1) << HSIZE;
   assign incr_addr  = last_addr + size_bytes;
   assign block_mask = (ADDR_W'(burst_len(burst_q)) << HSIZE) - ADDR_W'(1);
   assign seq_next   = burst_q[0] ? incr_addr
                                  : ((last_addr & ~block_mask) | (incr_addr & block_mask));

`ifdef SYNTHESIS
   assign xdata = 1'b0;
`else
   assign xdata = dp_done && (dp_write ? $isunknown(HWDATA) : (!HRESP && $isunknown(HRDATA)));
`endif

   always_comb begin
      viol    = '0;
      viol[0] = prev_pend && !resp_err &&
                (HADDR != prev_addr || HWRITE != prev_write ||
                 HSIZE != prev_size || HBURST != prev_burst);
      viol[1] = accept && is_seq && state == ST_BURST && HADDR != seq_next;
      viol[2] = HREADY && state == ST_BURST && fixed_q && !resp_err &&
                (((is_nonseq || is_idle) && beats_left != 5'd0) ||
                 (is_seq && beats_left == 5'd0));
      viol[3] = HREADY && (is_seq || is_busy) && state == ST_IDLE;
      viol[4] = !HREADY && wait_cnt == WAIT_W'(MAX_WAIT);
      viol[5] = accept && (({1'b0, HADDR} >= ADDR_LIMIT) ||
                (is_seq && state == ST_BURST && burst_q[0] &&
                 HADDR[ADDR_W-1:10] != last_addr[ADDR_W-1:10]));
      viol[6] = xdata;
   end

   // A finished fixed burst parks in BURST with zero beats left so an extra SEQ is caught as an overrun;
   // the following NONSEQ or IDLE then returns the FSM to IDLE.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= ST_IDLE;
         beats_left <= '0;
         burst_q    <= '0;
      end else if (resp_err) begin
         state      <= ST_IDLE;
         beats_left <= '0;
      end else if (HREADY) begin
         case (state)
            ST_IDLE: begin
               if (is_nonseq && HBURST != 3'd0) begin
                  state      <= ST_BURST;
                  burst_q    <= HBURST;
                  beats_left <= burst_len(HBURST) - 5'd1;
               end
            end
            ST_BURST: begin
               if (is_nonseq) begin
                  if (HBURST == 3'd0) begin
                     state      <= ST_IDLE;
                     beats_left <= '0;
                  end else begin
                     burst_q    <= HBURST;
                     beats_left <= burst_len(HBURST) - 5'd1;
                  end
               end else if (is_seq) begin
                  if (beats_left != 5'd0) beats_left <= beats_left - 5'd1;
               end else if (is_idle) begin
                  state      <= ST_IDLE;
                  beats_left <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid   <= 1'b0;
         dp_write   <= 1'b0;
         last_addr  <= '0;
         prev_addr  <= '0;
         prev_write <= 1'b0;
         prev_size  <= '0;
         prev_burst <= '0;
         prev_pend  <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         if (HREADY) begin
            dp_valid <= HTRANS[1];
            dp_write <= HWRITE;
         end
         if (accept) last_addr <= HADDR;
         prev_addr  <= HADDR;
         prev_write <= HWRITE;
         prev_size  <= HSIZE;
         prev_burst <= HBURST;
         prev_pend  <= !HREADY && HTRANS[1];
         if (HREADY)
            wait_cnt <= '0;
         else if (wait_cnt != WAIT_W'(MAX_WAIT + 1))
            wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Clear takes priority over any violation seen in the same cycle.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_pulse  <= '0;
         err_sticky <= '0;
         first_code <= '0;
         first_addr <= '0;
         xfer_cnt   <= '0;
         err_cnt    <= '0;
      end else if (clr) begin
         err_pulse  <= '0;
         err_sticky <= '0;
         first_code <= '0;
         first_addr <= '0;
         xfer_cnt   <= '0;
         err_cnt    <= '0;
      end else begin
         err_pulse  <= viol;
         err_sticky <= err_sticky | viol;
         if (err_sticky == 7'd0 && viol != 7'd0) begin
            first_code <= lowest_set(viol);
            first_addr <= HADDR;
         end
         if (viol != 7'd0 && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
         if (dp_done && !HRESP && xfer_cnt != '1) xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ahb_lite_protocol_checker.sv
// Scoreboard bench for ahb_lite_protocol_checker: expected err_pulse per bus cycle is queued when
// the cycle is driven and compared after the clock edge; end-of-scenario state is checked inline.
module tb_ahb_lite_protocol_checker;

   localparam int CNT_W = 5;

   localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
   localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_WRAP8 = 3'd4, B_INCR8 = 3'd5;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = T_IDLE;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'd2;
   logic [2:0]  HBURST = B_SINGLE;
   logic [31:0] HWDATA = 32'h1234_5678;
   logic [31:0] HRDATA = 32'hA5A5_A5A5;
   logic        HREADY = 1'b1;
   logic        HRESP = 1'b0;
   logic        clr = 1'b0;
   logic [6:0]  err_pulse, err_sticky;
   logic [2:0]  first_code;
   logic [31:0] first_addr;
   logic [CNT_W-1:0] xfer_cnt, err_cnt;

   int total = 0;
   int bad = 0;
   logic [6:0] exp_q[$];

   typedef struct {
      logic        c;
      logic [1:0]  t;
      logic [31:0] a;
      logic [2:0]  b;
      logic        r;
      logic [6:0]  e;
   } step_t;

   always #5 HCLK = ~HCLK;

   ahb_lite_protocol_checker #(
      .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3), .SLAVE_SPAN(1024), .MAX_WAIT(16), .CNT_W(CNT_W)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
      .HRESP(HRESP), .clr(clr), .err_pulse(err_pulse), .err_sticky(err_sticky),
      .first_code(first_code), .first_addr(first_addr), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
   );

   function automatic step_t mk(input logic c, input logic [1:0] t, input logic [31:0] a,
                                input logic [2:0] b, input logic r, input logic [6:0] e);
      step_t s;
      s.c = c; s.t = t; s.a = a; s.b = b; s.r = r; s.e = e;
      return s;
   endfunction

   task automatic drive(input step_t s);
      clr = s.c; HTRANS = s.t; HADDR = s.a; HBURST = s.b; HREADY = s.r;
      exp_q.push_back(s.e);
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset();
      HTRANS = T_NSEQ; HADDR = 32'hC00; HREADY = 1'b1;
      repeat (3) @(posedge HCLK);
      #1;
      total++; if (err_pulse !== 7'd0) begin bad++; $display("FAIL reset err_pulse got=%h want=0", err_pulse); end
      total++; if (err_sticky !== 7'd0) begin bad++; $display("FAIL reset err_sticky got=%h want=0", err_sticky); end
      total++; if (first_code !== 3'd0) begin bad++; $display("FAIL reset first_code got=%0d want=0", first_code); end
      total++; if (first_addr !== 32'd0) begin bad++; $display("FAIL reset first_addr got=%h want=0", first_addr); end
      total++; if (xfer_cnt !== '0) begin bad++; $display("FAIL reset xfer_cnt got=%0d want=0", xfer_cnt); end
      total++; if (err_cnt !== '0) begin bad++; $display("FAIL reset err_cnt got=%0d want=0", err_cnt); end
      HTRANS = T_IDLE; HADDR = '0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_incr4();
      step_t s[$];
      logic [6:0] got, want;
      HWRITE = 1'b1; HSIZE = 3'd2;
      s.push_back(mk(1, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h100, B_INCR4,  1, 7'h00));
      s.push_back(mk(0, T_SEQ,  32'h104, B_INCR4,  1, 7'h00));
      s.push_back(mk(0, T_SEQ,  32'h108, B_INCR4,  1, 7'h00));
      s.push_back(mk(0, T_SEQ,  32'h10C, B_INCR4,  1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      foreach (s[i]) begin
         drive(s[i]);
         got = err_pulse; want = exp_q.pop_front();
         total++;
         if (got !== want) begin bad++; $display("FAIL incr4 err_pulse step %0d got=%h want=%h", i, got, want); end
      end
      total++; if (err_sticky !== 7'd0) begin bad++; $display("FAIL incr4 err_sticky got=%h want=0", err_sticky); end
      total++; if (xfer_cnt !== 5'd4) begin bad++; $display("FAIL incr4 xfer_cnt got=%0d want=4", xfer_cnt); end
      total++; if (err_cnt !== 5'd0) begin bad++; $display("FAIL incr4 err_cnt got=%0d want=0", err_cnt); end
   endtask

   task automatic test_wrap8();
      step_t s[$];
      logic [6:0] got, want;
      logic [31:0] good [7] = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38};
      HWRITE = 1'b0; HSIZE = 3'd2;
      s.push_back(mk(1, T_IDLE, 32'h0,  B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h3C, B_WRAP8,  1, 7'h00));
      for (int k = 0; k < 7; k++) s.push_back(mk(0, T_SEQ, good[k], B_WRAP8, 1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,  B_SINGLE, 1, 7'h00));
      s.push_back(mk(1, T_IDLE, 32'h0,  B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h3C, B_WRAP8,  1, 7'h00));
      s.push_back(mk(0, T_SEQ,  32'h20, B_WRAP8,  1, 7'h00));
      s.push_back(mk(0, T_SEQ,  32'h40, B_WRAP8,  1, 7'h02));
      s.push_back(mk(0, T_SEQ,  32'h28, B_WRAP8,  1, 7'h02));
      for (int k = 3; k < 7; k++) s.push_back(mk(0, T_SEQ, good[k], B_WRAP8, 1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,  B_SINGLE, 1, 7'h00));
      foreach (s[i]) begin
         drive(s[i]);
         got = err_pulse; want = exp_q.pop_front();
         total++;
         if (got !== want) begin bad++; $display("FAIL wrap8 err_pulse step %0d got=%h want=%h", i, got, want); end
      end
      total++; if (err_sticky !== 7'h02) begin bad++; $display("FAIL wrap8 err_sticky got=%h want=02", err_sticky); end
      total++; if (first_code !== 3'd1) begin bad++; $display("FAIL wrap8 first_code got=%0d want=1", first_code); end
      total++; if (first_addr !== 32'h40) begin bad++; $display("FAIL wrap8 first_addr got=%h want=40", first_addr); end
   endtask

   task automatic test_incr8_early();
      step_t s[$];
      logic [6:0] got, want;
      s.push_back(mk(1, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h200, B_INCR8,  1, 7'h00));
      for (int k = 1; k < 5; k++) s.push_back(mk(0, T_SEQ, 32'h200 + 32'(4 * k), B_INCR8, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h300, B_SINGLE, 1, 7'h04));
      s.push_back(mk(0, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      foreach (s[i]) begin
         drive(s[i]);
         got = err_pulse; want = exp_q.pop_front();
         total++;
         if (got !== want) begin bad++; $display("FAIL incr8_early err_pulse step %0d got=%h want=%h", i, got, want); end
      end
      total++; if (first_code !== 3'd2) begin bad++; $display("FAIL incr8_early first_code got=%0d want=2", first_code); end
      total++; if (first_addr !== 32'h300) begin bad++; $display("FAIL incr8_early first_addr got=%h want=300", first_addr); end
      total++; if (err_cnt !== 5'd1) begin bad++; $display("FAIL incr8_early err_cnt got=%0d want=1", err_cnt); end
   endtask

   task automatic test_timeout_stable();
      step_t s[$];
      logic [6:0] got, want;
      s.push_back(mk(1, T_IDLE, 32'h0, B_SINGLE, 1, 7'h00));
      for (int k = 0; k < 18; k++) s.push_back(mk(0, T_IDLE, 32'h0, B_SINGLE, 0, (k == 16) ? 7'h10 : 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0, B_SINGLE, 1, 7'h00));
      for (int k = 0; k < 16; k++) s.push_back(mk(0, T_IDLE, 32'h0, B_SINGLE, 0, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,  B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h80, B_SINGLE, 0, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h84, B_SINGLE, 0, 7'h01));
      s.push_back(mk(0, T_NSEQ, 32'h84, B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,  B_SINGLE, 1, 7'h00));
      foreach (s[i]) begin
         drive(s[i]);
         got = err_pulse; want = exp_q.pop_front();
         total++;
         if (got !== want) begin bad++; $display("FAIL timeout_stable err_pulse step %0d got=%h want=%h", i, got, want); end
      end
      total++; if (err_cnt !== 5'd2) begin bad++; $display("FAIL timeout_stable err_cnt got=%0d want=2", err_cnt); end
      total++; if (first_code !== 3'd4) begin bad++; $display("FAIL timeout_stable first_code got=%0d want=4", first_code); end
   endtask

   task automatic test_range_orphan();
      step_t s[$];
      logic [6:0] got, want;
      s.push_back(mk(1, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'hC00, B_SINGLE, 1, 7'h20));
      s.push_back(mk(0, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'hBFC, B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_SEQ,  32'h10,  B_SINGLE, 1, 7'h08));
      s.push_back(mk(0, T_BUSY, 32'h14,  B_SINGLE, 1, 7'h08));
      s.push_back(mk(0, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h3F8, B_INCR,   1, 7'h00));
      s.push_back(mk(0, T_SEQ,  32'h3FC, B_INCR,   1, 7'h00));
      s.push_back(mk(0, T_SEQ,  32'h400, B_INCR,   1, 7'h20));
      s.push_back(mk(0, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      foreach (s[i]) begin
         drive(s[i]);
         got = err_pulse; want = exp_q.pop_front();
         total++;
         if (got !== want) begin bad++; $display("FAIL range_orphan err_pulse step %0d got=%h want=%h", i, got, want); end
      end
      total++; if (err_sticky !== 7'h28) begin bad++; $display("FAIL range_orphan err_sticky got=%h want=28", err_sticky); end
      total++; if (first_code !== 3'd5) begin bad++; $display("FAIL range_orphan first_code got=%0d want=5", first_code); end
      total++; if (first_addr !== 32'hC00) begin bad++; $display("FAIL range_orphan first_addr got=%h want=c00", first_addr); end
      total++; if (err_cnt !== 5'd4) begin bad++; $display("FAIL range_orphan err_cnt got=%0d want=4", err_cnt); end
   endtask

   task automatic test_back_to_back();
      step_t s[$];
      logic [6:0] got, want;
      s.push_back(mk(1, T_IDLE, 32'h0, B_SINGLE, 1, 7'h00));
      for (int k = 0; k < 31; k++) s.push_back(mk(0, T_NSEQ, 32'h0, B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0, B_SINGLE, 1, 7'h00));
      foreach (s[i]) begin
         drive(s[i]);
         got = err_pulse; want = exp_q.pop_front();
         total++;
         if (got !== want) begin bad++; $display("FAIL back_to_back err_pulse step %0d got=%h want=%h", i, got, want); end
      end
      total++; if (xfer_cnt !== 5'd31) begin bad++; $display("FAIL back_to_back xfer_cnt at max got=%0d want=31", xfer_cnt); end
      s.delete();
      for (int k = 0; k < 9; k++) s.push_back(mk(0, T_NSEQ, 32'h0, B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0, B_SINGLE, 1, 7'h00));
      for (int k = 0; k < 35; k++) s.push_back(mk(0, T_BUSY, 32'h44, B_SINGLE, 1, 7'h08));
      foreach (s[i]) begin
         drive(s[i]);
         got = err_pulse; want = exp_q.pop_front();
         total++;
         if (got !== want) begin bad++; $display("FAIL back_to_back sat err_pulse step %0d got=%h want=%h", i, got, want); end
      end
      total++; if (xfer_cnt !== 5'd31) begin bad++; $display("FAIL back_to_back xfer_cnt saturated got=%0d want=31", xfer_cnt); end
      total++; if (err_cnt !== 5'd31) begin bad++; $display("FAIL back_to_back err_cnt saturated got=%0d want=31", err_cnt); end
      total++; if (first_addr !== 32'h44) begin bad++; $display("FAIL back_to_back first_addr got=%h want=44", first_addr); end
   endtask

   task automatic test_clr();
      step_t s[$];
      logic [6:0] got, want;
      s.push_back(mk(1, T_BUSY, 32'h48, B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,  B_SINGLE, 1, 7'h00));
      foreach (s[i]) begin
         drive(s[i]);
         got = err_pulse; want = exp_q.pop_front();
         total++;
         if (got !== want) begin bad++; $display("FAIL clr err_pulse step %0d got=%h want=%h", i, got, want); end
      end
      total++; if (err_sticky !== 7'd0) begin bad++; $display("FAIL clr err_sticky got=%h want=0", err_sticky); end
      total++; if (err_cnt !== 5'd0) begin bad++; $display("FAIL clr err_cnt got=%0d want=0", err_cnt); end
      total++; if (xfer_cnt !== 5'd0) begin bad++; $display("FAIL clr xfer_cnt got=%0d want=0", xfer_cnt); end
      total++; if (first_code !== 3'd0) begin bad++; $display("FAIL clr first_code got=%0d want=0", first_code); end
      total++; if (first_addr !== 32'd0) begin bad++; $display("FAIL clr first_addr got=%h want=0", first_addr); end
   endtask

   task automatic test_reset_midburst();
      step_t s[$];
      logic [6:0] got, want;
      s.push_back(mk(1, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h100, B_INCR4,  1, 7'h00));
      s.push_back(mk(0, T_SEQ,  32'h104, B_INCR4,  1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_NSEQ, 32'h200, B_SINGLE, 1, 7'h00));
      s.push_back(mk(0, T_IDLE, 32'h0,   B_SINGLE, 1, 7'h00));
      foreach (s[i]) begin
         drive(s[i]);
         got = err_pulse; want = exp_q.pop_front();
         total++;
         if (got !== want) begin bad++; $display("FAIL reset_midburst err_pulse step %0d got=%h want=%h", i, got, want); end
         if (i == 2) begin
            HTRANS = T_IDLE; HRESETn = 1'b0;
            #2;
            total++;
            if (xfer_cnt !== 5'd0) begin bad++; $display("FAIL reset_midburst async xfer_cnt got=%0d want=0", xfer_cnt); end
            @(posedge HCLK);
            @(negedge HCLK);
            HRESETn = 1'b1;
         end
      end
      total++; if (err_sticky !== 7'd0) begin bad++; $display("FAIL reset_midburst err_sticky got=%h want=0", err_sticky); end
      total++; if (xfer_cnt !== 5'd1) begin bad++; $display("FAIL reset_midburst xfer_cnt got=%0d want=1", xfer_cnt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_incr4();
      test_wrap8();
      test_incr8_early();
      test_timeout_stable();
      test_range_orphan();
      test_back_to_back();
      test_clr();
      test_reset_midburst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
